blk_ee5a7a: RTL
===============

// Module: candy_avb_test_qsys_nios2_0_cpu_debug_vjtag_master
// PURPOSE
//  Initiator side of the Nios II debug virtual-JTAG protocol: turns one system-clock command
//  (IR + DR word) into a full UIR/CDR/SDR/UDR/RTI scan towards the debug slave and returns the
//  captured DR. Replaces the sld hub in test fabrics/sim so the debug slave runs without a cable.
// PARAMETERS
//  DR_WIDTH    38  scan chain length (matches debug slave sr/jdo width)
//  IR_WIDTH    2   virtual IR width
//  TCK_HALF    2   clk cycles per tck half-period (>=1)
//  RTI_CYCLES  1   tck periods spent in run-test-idle after UDR (>=1)
// PORTS
//  clk             in   1         system clock; all logic on rising edge
//  reset           in   1         synchronous, active-high
//  cmd_valid       in   1         command present
//  cmd_ready       out  1         command accepted when valid&ready
//  cmd_ir          in   IR_WIDTH  virtual IR to load
//  cmd_dr          in   DR_WIDTH  DR value to shift in, LSB first
//  rsp_valid       out  1         captured DR available; held until rsp_ready
//  rsp_ready       in   1         response consumed
//  rsp_data        out  DR_WIDTH  DR shifted out of slave (tdo), bit0 = first bit out
//  busy            out  1         scan in progress (state != IDLE)
//  tck             out  1         generated scan clock, registered
//  tdi             out  1         serial data to slave
//  tdo             in   1         serial data from slave
//  ir_in           out  IR_WIDTH  virtual IR presented to slave
//  vs_uir,vs_cdr,vs_sdr,vs_udr out 1  virtual-state flags, one-hot with jtag_state_rti or all 0
//  jtag_state_rti  out  1         run-test-idle flag
// BEHAVIOUR
//  - Reset: state IDLE; tck,tdi,busy,rsp_valid,all vs_*,jtag_state_rti = 0; ir_in = 0;
//    rsp_data = 0; cmd_ready = 0 while reset high. Reset mid-scan aborts; no response issued.
//  - cmd_ready = (state==IDLE) & !rsp_valid & !reset. New command blocked until rsp consumed.
//  - FSM: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> IDLE. Every state except IDLE lasts whole
//    tck periods of 2*TCK_HALF clk: UIR/CDR/UDR 1 period, SDR DR_WIDTH periods, RTI RTI_CYCLES.
//  - tck: 0 in IDLE; in each period low for first TCK_HALF clk, high for second TCK_HALF clk.
//    State, vs_* flags and tdi change only at period start (tck falling / low phase entry).
//  - Accept: ir_in <= cmd_ir, sr <= cmd_dr; ir_in stays stable until the next accept.
//  - SDR: tdi = sr[0]; tdo registered on clk where tck rises (tdo_q); at end of each SDR period
//    sr <= {tdo_q, sr[DR_WIDTH-1:1]}. Shift counter runs 0..DR_WIDTH-1, exits SDR on DR_WIDTH-1.
//  - tdi = 0 outside SDR. Exactly one of vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti high per
//    active state; none in IDLE.
//  - On RTI exit: rsp_data <= sr, rsp_valid <= 1 (same clk state returns to IDLE).
//    rsp_valid clears on clk after rsp_valid&rsp_ready; cmd_ready rises same cycle it clears.
//  - Latency accept->rsp_valid = 2*TCK_HALF*(3+DR_WIDTH+RTI_CYCLES) clk (defaults: 168).
//  - cmd_valid with cmd_ready low: ignored, no side effects; inputs sampled only at accept.
//  - Counters sized for max(DR_WIDTH,RTI_CYCLES,TCK_HALF); no wrap within a scan.
// CONFIGURATION
//  VJTAG_MASTER_SKIP_IR_EN defined: last_ir + last_ir_vld (cleared by reset) kept; if
//    last_ir_vld & cmd_ir==last_ir at accept, UIR is skipped (IDLE->CDR), latency shrinks by
//    2*TCK_HALF clk; otherwise UIR runs and last_ir updates.
//  Not defined: UIR always executed; no last_ir state.
// TESTING
//  1 Reset: hold reset 3 clk mid-SDR -> all outputs 0, busy 0, no rsp_valid; cmd_ready 1 next clk.
//  2 Loopback tdo=tdi delayed 1 period, cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_A5A5 -> rsp_data =
//    {cmd_dr[36:0],1'b0}; rsp_valid exactly 168 clk after accept; vs_sdr high 152 clk.
//  3 tdo tied 1, cmd_dr=0 -> rsp_data=38'h3F_FFFF_FFFF; tdi 0 throughout.
//  4 Backpressure: rsp_ready low 20 clk with cmd_valid high -> cmd_ready 0, rsp_data stable,
//    second command accepted cycle rsp_valid drops.
//  5 SKIP_IR_EN: two back-to-back cmd_ir=2'b10 -> 2nd scan has no vs_uir, latency 164 clk;
//    then cmd_ir=2'b11 -> vs_uir present. Macro off: vs_uir every scan.
//  6 Protocol checker: one-hot vs_*/rti, tdi/vs_* change only while tck low, ir_in stable in scan.

Source files
------------

// File: rtl/blk_ee5a7a.sv
// Virtual-JTAG debug master: turns one IR+DR command into a UIR/CDR/SDR/UDR/RTI scan and returns the captured DR.
// Optional VJTAG_MASTER_SKIP_IR_EN skips UIR when the command IR matches the last IR loaded.
//
// state | meaning
// IDLE  | no scan; tck parked low, waiting for a command
// UIR   | update-IR period, ir_in presented to slave
// CDR   | capture-DR period
// SDR   | shift-DR, one bit per tck period (DR_WIDTH periods)
// UDR   | update-DR period
// RTI   | run-test-idle for RTI_CYCLES periods, then response issued
module blk_ee5a7a #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int CNT_A   = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CNT_TOP = (CNT_A > TCK_HALF) ? CNT_A : TCK_HALF;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam int PW      = $clog2(2 * TCK_HALF);

  localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_HALF - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(TCK_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(TCK_HALF);
  localparam logic [CW-1:0] DR_LAST  = CW'(DR_WIDTH - 1);
  localparam logic [CW-1:0] RTI_LAST = CW'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       ph, ph_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [DR_WIDTH-1:0] sr;
  logic                tdo_q;
  logic                tck_nxt;
  logic                accept;
  logic                period_end;
  logic                skip_uir;
  logic                scan_done;

`ifdef VJTAG_MASTER_SKIP_IR_EN
  logic [IR_WIDTH-1:0] last_ir;
  logic                last_ir_vld;
`endif

  assign cmd_ready      = (state == S_IDLE) & ~rsp_valid & ~reset;
  assign accept         = cmd_valid & cmd_ready;
  assign period_end     = (ph == PH_LAST);
  assign scan_done      = (state == S_RTI) & period_end & (cnt == RTI_LAST);
  assign busy           = (state != S_IDLE);
  assign tdi            = (state == S_SDR) & sr[0];
  assign vs_uir         = (state == S_UIR);
  assign vs_cdr         = (state == S_CDR);
  assign vs_sdr         = (state == S_SDR);
  assign vs_udr         = (state == S_UDR);
  assign jtag_state_rti = (state == S_RTI);

  always_comb begin
    skip_uir = 1'b0;
`ifdef VJTAG_MASTER_SKIP_IR_EN
    skip_uir = last_ir_vld & (cmd_ir == last_ir);
`endif
  end

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    cnt_nxt   = cnt;
    if (state == S_IDLE) begin
      ph_nxt  = '0;
      cnt_nxt = '0;
      if (accept) state_nxt = skip_uir ? S_CDR : S_UIR;
    end else begin
      ph_nxt = period_end ? '0 : ph + PW'(1);
      if (period_end) begin
        case (state)
          S_UIR: state_nxt = S_CDR;
          S_CDR: begin
            state_nxt = S_SDR;
            cnt_nxt   = '0;
          end
          S_SDR: begin
            if (cnt == DR_LAST) begin
              state_nxt = S_UDR;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
          S_UDR: begin
            state_nxt = S_RTI;
            cnt_nxt   = '0;
          end
          S_RTI: begin
            if (cnt == RTI_LAST) state_nxt = S_IDLE;
            else                 cnt_nxt   = cnt + CW'(1);
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
    // tck is registered from the next phase so it is glitch-free and aligned to state changes
    tck_nxt = (state_nxt != S_IDLE) & (ph_nxt >= PH_HIGH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ph        <= '0;
      cnt       <= '0;
      tck       <= 1'b0;
      sr        <= '0;
      tdo_q     <= 1'b0;
      ir_in     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
`ifdef VJTAG_MASTER_SKIP_IR_EN
      last_ir     <= '0;
      last_ir_vld <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ph    <= ph_nxt;
      cnt   <= cnt_nxt;
      tck   <= tck_nxt;
      if (accept) begin
        ir_in <= cmd_ir;
        sr    <= cmd_dr;
`ifdef VJTAG_MASTER_SKIP_IR_EN
        last_ir     <= cmd_ir;
        last_ir_vld <= 1'b1;
`endif
      end
      if ((state == S_SDR) && (ph == PH_RISE)) tdo_q <= tdo;
      if ((state == S_SDR) && period_end) sr <= {tdo_q, sr[DR_WIDTH-1:1]};
      if (scan_done) begin
        rsp_data  <= sr;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
